// File: rtl/fp_shift_pkg.sv
// Shared types for the iterative shift unit: operation modes and control FSM states.
package fp_shift_pkg;

    typedef enum logic [2:0] {
        MODE_LSR  = 3'd0,
        MODE_ASR  = 3'd1,
        MODE_LSL  = 3'd2,
        MODE_ROL  = 3'd3,
        MODE_NORM = 3'd4
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_e;

    // Encodings above NORM carry the operand through untouched.
    function automatic logic is_pass_mode(input logic [2:0] mode);
        return (mode > 3'd4);
    endfunction

endpackage

// File: rtl/leading_zero_count.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
// Zero latency, no flow control.
module leading_zero_count #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0]         i_data,
    output logic [$clog2(WIDTH):0]   o_count,
    output logic                     o_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    // Scanning upward lets the highest set bit have the final say.
    always_comb begin
        o_count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_count = CW'(WIDTH - 1 - i);
            end
        end
    end

    assign o_zero = ~|i_data;

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle shifter/normaliser moving at most STEP bits per cycle; latency 1 + ceil(n_eff/STEP).
// o_ready drops while shifting; a finished result is held until i_ready, with back-to-back accept.
module iterative_shift_unit
    import fp_shift_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int STEP  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [WIDTH-1:0]          i_data,
    input  logic [2:0]                i_mode,
    input  logic [$clog2(WIDTH):0]    i_shift_n,
    input  logic                      i_fill_one,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_sticky,
    output logic [$clog2(WIDTH):0]    o_shift_count
);

    localparam int            CW      = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0] STEP_C  = CW'(STEP);

    shift_state_e      r_state;
    shift_state_e      w_state_nxt;
    shift_mode_e       r_mode;
    logic [WIDTH-1:0]  r_data;
    logic              r_sticky;
    logic              r_fill;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_remaining;

    shift_mode_e       w_mode;
    logic              w_pass;
    logic              w_accept;
    logic              w_direct;
    logic [CW-1:0]     w_n_eff;
    logic [CW-1:0]     w_lz;
    logic              w_lz_zero;
    logic [CW-1:0]     w_step;
    logic [WIDTH-1:0]  w_low_mask;
    logic [WIDTH-1:0]  w_shifted;
    logic              w_out_bits;

    leading_zero_count #(
        .WIDTH (WIDTH)
    ) u_lzc (
        .i_data  (i_data),
        .o_count (w_lz),
        .o_zero  (w_lz_zero)
    );

    assign w_mode   = shift_mode_e'(i_mode);
    assign w_pass   = is_pass_mode(i_mode);
    assign o_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & i_ready);
    assign w_accept = i_valid & o_ready;

    assign o_valid       = (r_state == ST_DONE);
    assign o_data        = r_data;
    assign o_sticky      = r_sticky;
    assign o_shift_count = r_count;

    // Effective amount latched at acceptance; pass-through modes report zero.
    always_comb begin
        w_n_eff = '0;
        if (!w_pass) begin
            case (w_mode)
                MODE_LSR, MODE_ASR, MODE_LSL: w_n_eff = (i_shift_n > WIDTH_C) ? WIDTH_C : i_shift_n;
                MODE_ROL:                     w_n_eff = i_shift_n % WIDTH_C;
                MODE_NORM:                    w_n_eff = w_lz;
                default:                      w_n_eff = '0;
            endcase
        end
    end

    assign w_direct = w_pass | (w_n_eff == '0) | ((w_mode == MODE_NORM) & w_lz_zero);

    assign w_step     = (r_remaining > STEP_C) ? STEP_C : r_remaining;
    assign w_low_mask = ~({WIDTH{1'b1}} << w_step);

    always_comb begin
        w_shifted  = r_data;
        w_out_bits = 1'b0;
        case (r_mode)
            MODE_LSR: begin
                w_shifted  = r_data >> w_step;
                w_out_bits = |(r_data & w_low_mask);
            end
            MODE_ASR: begin
                w_shifted  = $unsigned($signed(r_data) >>> w_step);
                w_out_bits = |(r_data & w_low_mask);
            end
            MODE_LSL, MODE_NORM: begin
                w_shifted = (r_data << w_step) | (r_fill ? w_low_mask : '0);
            end
            MODE_ROL: begin
                w_shifted = (r_data << w_step) | (r_data >> (WIDTH_C - w_step));
            end
            default: begin
                w_shifted = r_data;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_direct ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_remaining == w_step) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_direct ? ST_DONE : ST_SHIFT;
                end else if (i_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mode      <= MODE_LSR;
            r_data      <= '0;
            r_sticky    <= 1'b0;
            r_fill      <= 1'b0;
            r_count     <= '0;
            r_remaining <= '0;
        end else if (w_accept) begin
            r_mode      <= w_mode;
            r_data      <= i_data;
            r_sticky    <= 1'b0;
            r_fill      <= i_fill_one & (w_mode == MODE_LSL) & ~w_pass;
            r_count     <= w_n_eff;
            r_remaining <= w_direct ? '0 : w_n_eff;
        end else if (r_state == ST_SHIFT) begin
            r_data      <= w_shifted;
            r_sticky    <= r_sticky | w_out_bits;
            r_remaining <= r_remaining - w_step;
        end
    end

endmodule

// File: doc/iterative_shift_unit.md
ITERATIVE_SHIFT_UNIT -- requirements
Module: iterative_shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width in bits (>= 8).
REQ-002 SHALL have parameter STEP, default 8, maximum bits shifted per cycle (power of two, 1..WIDTH).
REQ-003 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_valid  input  1  request valid.
REQ-006 SHALL have port o_ready  output  1  unit can accept a request this cycle.
REQ-007 SHALL have port i_data  input  WIDTH  operand.
REQ-008 SHALL have port i_mode  input  3  0 LSR, 1 ASR, 2 LSL, 3 ROL, 4 NORM, 5-7 pass-through.
REQ-009 SHALL have port i_shift_n  input  $clog2(WIDTH)+1  requested shift amount (ignored in NORM).
REQ-010 SHALL have port i_fill_one  input  1  LSL only: vacated LSBs fill with 1 instead of 0.
REQ-011 SHALL have port o_valid  output  1  result valid.
REQ-012 SHALL have port i_ready  input  1  downstream accepts result.
REQ-013 SHALL have port o_data  output  WIDTH  result.
REQ-014 SHALL have port o_sticky  output  1  OR of all bits shifted out of bit 0 (LSR/ASR), else 0.
REQ-015 SHALL have port o_shift_count  output  $clog2(WIDTH)+1  NORM: leading-zero count; other modes: effective amount n_eff.

Function
REQ-016 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE; request accepted on rising edge with i_valid & o_ready.
REQ-017 SHALL drive o_ready = 1 in IDLE, = i_ready in DONE, 0 in SHIFT.
REQ-018 SHALL compute n_eff = min(i_shift_n, WIDTH) for LSR/ASR/LSL, i_shift_n mod WIDTH for ROL.
REQ-019 On acceptance with n_eff = 0 (or pass-through mode) SHALL load operand and go directly to DONE; otherwise go to SHIFT.
REQ-020 Each SHIFT cycle SHALL shift by min(remaining, STEP) and decrement remaining; when remaining reaches 0, go to DONE.
REQ-021 Latency acceptance-edge to o_valid SHALL be 1 + ceil(n_eff/STEP) cycles.
REQ-022 LSR fills MSBs with 0; ASR replicates original bit WIDTH-1; LSL fills LSBs with i_fill_one; ROL rotates left.
REQ-023 n_eff = WIDTH SHALL yield LSR 0, ASR all-sign, LSL all-zero or all-one per i_fill_one.
REQ-024 o_sticky SHALL accumulate across SHIFT cycles and clear on each acceptance.
REQ-025 NORM SHALL shift left by min(lz(current), STEP) per SHIFT cycle until MSB = 1; latency 1 + ceil(lz/STEP); o_shift_count = total lz.
REQ-026 NORM with zero operand SHALL go directly to DONE with o_data 0, o_shift_count WIDTH.
REQ-027 In DONE, o_valid = 1 and o_data/o_sticky/o_shift_count SHALL hold stable until i_ready = 1.
REQ-028 DONE with i_ready & i_valid SHALL accept the next request in the same edge (back-to-back, no bubble).
REQ-029 i_data/i_mode/i_shift_n/i_fill_one SHALL be sampled only at acceptance; changes afterward have no effect.

Reset
REQ-030 i_rst = 1 SHALL immediately force IDLE, o_valid 0, o_data 0, o_sticky 0, o_shift_count 0, remaining 0; o_ready 1 once i_rst releases.
REQ-031 Reset during SHIFT or DONE SHALL discard the operation with no result emitted.

Structure
REQ-032 Package fp_shift_pkg SHALL hold the mode enum (LSR, ASR, LSL, ROL, NORM) and FSM state enum.
REQ-033 Leading-zero count SHALL be a sub-module leading_zero_count #(WIDTH), reused for NORM.

Verification (WIDTH=16, STEP=4)
REQ-034 LSR 0x8001 by 5 -> o_valid 3 cycles after acceptance, o_data 0x0400, o_sticky 1, o_shift_count 5.
REQ-035 ASR 0x8000 by 20 -> n_eff 16, latency 5, o_data 0xFFFF, o_sticky 1, o_shift_count 16.
REQ-036 NORM 0x0010 -> latency 4, o_data 0x8000, o_shift_count 11; NORM 0x0000 -> latency 1, o_data 0, count 16.
REQ-037 LSL 0x0003 by 3 fill_one=1 -> latency 2, o_data 0x001F; ROL 0x8001 by 17 -> latency 2, o_data 0x0003.
REQ-038 i_ready low 3 cycles in DONE -> outputs stable, o_ready 0; then i_ready & i_valid high -> new request accepted same edge.
REQ-039 i_rst pulse mid-SHIFT -> o_valid 0 and o_data 0 immediately, no result emitted, o_ready 1 after release.
